// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared state type and length-width helper for dma_tx_burst
package dma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      READ,
      SEND,
      TXBUSY,
      TXDONE,
      CSUM
   } dma_tx_state_t;

   // Width needed to hold byte counts 0..max_len inclusive
   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/dma_tx_burst.sv
// rtl/dma_tx_burst.sv - block DMA reader streaming RAM bytes to a UART TX; DMA_TX_CHECKSUM_EN appends an XOR byte
module dma_tx_burst
   import dma_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = len_w(MAX_LEN)
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Ena,
   input  logic              Start,
   input  logic [ADDR_W-1:0] Base_addr,
   input  logic [LEN_W-1:0]  Length,
   input  logic [DATA_W-1:0] Databus,
   input  logic              Bus_grant,
   input  logic              TX_Ready,
   output logic [ADDR_W-1:0] Address,
   output logic              Cs,
   output logic              Oen,
   output logic              Bus_req,
   output logic              TX_Valid,
   output logic [DATA_W-1:0] TX_Data,
   output logic              Dma_Ready,
   output logic              Done
);

   dma_tx_state_t     state;
   dma_tx_state_t     state_nx;
   logic [ADDR_W-1:0] ptr;
   logic [LEN_W-1:0]  cnt;
   logic [LEN_W-1:0]  len_sat;
   logic [DATA_W-1:0] tx_data_q;
   logic              done_q;
   logic              done_set;
   logic              tx_strobe;
   logic              start_ok;
   logic              byte_done;
   logic              last_byte;

`ifdef DMA_TX_CHECKSUM_EN
   logic [DATA_W-1:0] csum;
   logic              csum_phase;
`endif

   assign len_sat   = (Length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : Length;
   assign start_ok  = (state == IDLE) && Start && Ena;
   assign byte_done = Ena && (state == TXDONE) && TX_Ready;
   assign last_byte = (cnt == LEN_W'(1));

   // Next-state selection; Ena low aborts to IDLE from anywhere without a Done pulse
   always_comb begin
      state_nx  = state;
      tx_strobe = 1'b0;
      done_set  = 1'b0;
      if (!Ena) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  if (len_sat == '0) done_set = 1'b1;
                  else               state_nx = REQ;
               end
            end
            REQ: begin
               if (Bus_grant) state_nx = READ;
            end
            READ: begin
               state_nx = SEND;
            end
            SEND: begin
               if (TX_Ready) begin
                  tx_strobe = 1'b1;
                  state_nx  = TXBUSY;
               end
            end
            TXBUSY: begin
               if (!TX_Ready) state_nx = TXDONE;
            end
            TXDONE: begin
               if (TX_Ready) begin
`ifdef DMA_TX_CHECKSUM_EN
                  if (csum_phase) begin
                     done_set = 1'b1;
                     state_nx = IDLE;
                  end else if (last_byte) begin
                     state_nx = CSUM;
                  end else begin
                     state_nx = REQ;
                  end
`else
                  if (last_byte) begin
                     done_set = 1'b1;
                     state_nx = IDLE;
                  end else begin
                     state_nx = REQ;
                  end
`endif
               end
            end
            CSUM: begin
`ifdef DMA_TX_CHECKSUM_EN
               state_nx = SEND;
`else
               state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Block pointer/counter, captured byte, checksum and registered Done pulse
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ptr       <= '0;
         cnt       <= '0;
         tx_data_q <= '0;
         done_q    <= 1'b0;
`ifdef DMA_TX_CHECKSUM_EN
         csum       <= '0;
         csum_phase <= 1'b0;
`endif
      end else begin
         done_q <= done_set;
         if (start_ok) begin
            ptr <= Base_addr;
            cnt <= len_sat;
`ifdef DMA_TX_CHECKSUM_EN
            csum       <= '0;
            csum_phase <= 1'b0;
`endif
         end
         if (Ena && state == READ) begin
            tx_data_q <= Databus;
`ifdef DMA_TX_CHECKSUM_EN
            csum <= csum ^ Databus;
`endif
         end
`ifdef DMA_TX_CHECKSUM_EN
         if (Ena && state == CSUM) begin
            tx_data_q  <= csum;
            csum_phase <= 1'b1;
         end
         if (byte_done && !csum_phase) begin
            ptr <= ptr + 1'b1;
            cnt <= cnt - 1'b1;
         end
`else
         if (byte_done) begin
            ptr <= ptr + 1'b1;
            cnt <= cnt - 1'b1;
         end
`endif
      end
   end

   // The bus is only held in REQ/READ, so it is released between bytes
   assign Dma_Ready = (state == IDLE);
   assign Bus_req   = (state == REQ) || (state == READ);
   assign Cs        = (state == READ);
   assign Oen       = ~Cs;
   assign Address   = ptr;
   assign TX_Valid  = tx_strobe;
   assign TX_Data   = tx_data_q;
   assign Done      = done_q;

endmodule

// File: tb/tb_dma_tx_burst.sv
// tb/tb_dma_tx_burst.sv - directed bench for dma_tx_burst with RAM, arbiter and UART TX models
module tb_dma_tx_burst;

`ifdef DMA_TX_CHECKSUM_EN
   localparam int CS_EXTRA = 1;
`else
   localparam int CS_EXTRA = 0;
`endif
   localparam int FRAME = 8;

   logic       Clk;
   logic       Rst;
   logic       Ena;
   logic       Start;
   logic [7:0] Base_addr;
   logic [4:0] Length;
   logic [7:0] Databus;
   logic       Bus_grant;
   logic       TX_Ready;
   logic [7:0] Address;
   logic       Cs;
   logic       Oen;
   logic       Bus_req;
   logic       TX_Valid;
   logic [7:0] TX_Data;
   logic       Dma_Ready;
   logic       Done;

   int errors = 0;
   int checks = 0;

   logic [7:0] ram [256];
   int         grant_delay = 1;
   int         req_cnt = 0;
   int         ucnt = 0;
   int         cyc = 0;

   logic [7:0] addr_q[$];
   logic [7:0] frame_q[$];
   int done_cnt, breq_cnt, cs_cnt, txv_cnt, frames_at_done, cs_oen_bad;
   int first_req, first_grant, first_cs, cs_early;

   dma_tx_burst dut (
      .Clk(Clk), .Rst(Rst), .Ena(Ena), .Start(Start), .Base_addr(Base_addr),
      .Length(Length), .Databus(Databus), .Bus_grant(Bus_grant), .TX_Ready(TX_Ready),
      .Address(Address), .Cs(Cs), .Oen(Oen), .Bus_req(Bus_req), .TX_Valid(TX_Valid),
      .TX_Data(TX_Data), .Dma_Ready(Dma_Ready), .Done(Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   // Combinational RAM and an arbiter granting after grant_delay request cycles
   assign Databus   = (Cs && !Oen) ? ram[Address] : 8'h00;
   assign Bus_grant = Bus_req && (req_cnt >= grant_delay);
   always @(posedge Clk) req_cnt <= Bus_req ? req_cnt + 1 : 0;

   // UART TX: busy for FRAME cycles after each accepted byte
   always @(posedge Clk) begin
      if (Rst) begin
         TX_Ready <= 1'b1;
         ucnt     <= 0;
      end else if (TX_Valid) begin
         TX_Ready <= 1'b0;
         ucnt     <= FRAME;
      end else if (ucnt > 0) begin
         ucnt <= ucnt - 1;
         if (ucnt == 1) TX_Ready <= 1'b1;
      end
   end

   // Bus/UART monitor sampled on the falling edge
   always @(negedge Clk) begin
      if (!Rst) begin
         if (Cs) begin addr_q.push_back(Address); cs_cnt++; end
         if (Cs && Oen) cs_oen_bad++;
         if (Bus_req) breq_cnt++;
         if (TX_Valid) begin frame_q.push_back(TX_Data); txv_cnt++; end
         if (Done) begin done_cnt++; frames_at_done = frame_q.size(); end
         if (Bus_req && first_req < 0) first_req = cyc;
         if (Bus_grant && first_grant < 0) first_grant = cyc;
         if (Cs && first_cs < 0) first_cs = cyc;
         if (Cs && first_grant < 0) cs_early++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge Clk);
      #1;
   endtask

   task automatic clr();
      addr_q.delete();
      frame_q.delete();
      done_cnt = 0; breq_cnt = 0; cs_cnt = 0; txv_cnt = 0; frames_at_done = -1;
      cs_oen_bad = 0; first_req = -1; first_grant = -1; first_cs = -1; cs_early = 0;
   endtask

   task automatic do_start(input logic [7:0] base, input logic [4:0] len);
      @(negedge Clk);
      Base_addr = base;
      Length    = len;
      Start     = 1'b1;
      @(negedge Clk);
      #1;
      Start     = 1'b0;
      Base_addr = 8'h99;
      Length    = 5'd7;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick(1);
         n++;
      end
      check({tag, "_done_seen"}, (done_cnt > 0) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      Rst = 1'b1; Ena = 1'b1; Start = 1'b0; Base_addr = 8'h00; Length = 5'd0;
      for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
      ram[8'h10] = 8'hAA; ram[8'h11] = 8'hBB;
      ram[8'hFE] = 8'h01; ram[8'hFF] = 8'h02; ram[8'h00] = 8'h03; ram[8'h01] = 8'h04;
      ram[8'h20] = 8'h5C;
      ram[8'h30] = 8'h11; ram[8'h31] = 8'h22; ram[8'h32] = 8'h33; ram[8'h33] = 8'h44; ram[8'h34] = 8'h55;
      ram[8'h40] = 8'h12; ram[8'h41] = 8'h34; ram[8'h42] = 8'h56;
      clr();
      tick(3);

      check("rst_address",   32'(Address),   32'h0);
      check("rst_cs",        32'(Cs),        32'h0);
      check("rst_oen",       32'(Oen),       32'h1);
      check("rst_bus_req",   32'(Bus_req),   32'h0);
      check("rst_tx_valid",  32'(TX_Valid),  32'h0);
      check("rst_tx_data",   32'(TX_Data),   32'h0);
      check("rst_dma_ready", 32'(Dma_Ready), 32'h1);
      check("rst_done",      32'(Done),      32'h0);
      @(negedge Clk);
      Rst = 1'b0;
      tick(2);

      // 1: two bytes from 0x10
      clr();
      grant_delay = 1;
      do_start(8'h10, 5'd2);
      check("t1_bus_req_lat", 32'(Bus_req),   32'h1);
      check("t1_busy",        32'(Dma_Ready), 32'h0);
      wait_done("t1", 1500);
      check("t1_frames_n", 32'(frame_q.size()), 32'(2 + CS_EXTRA));
      check("t1_frame0",   32'(frame_q[0]), 32'hAA);
      check("t1_frame1",   32'(frame_q[1]), 32'hBB);
`ifdef DMA_TX_CHECKSUM_EN
      check("t1_csum",     32'(frame_q[2]), 32'h11);
`endif
      check("t1_addr0",    32'(addr_q[0]), 32'h10);
      check("t1_addr1",    32'(addr_q[1]), 32'h11);
      check("t1_done_after_frames", 32'(frames_at_done), 32'(2 + CS_EXTRA));
      check("t1_ready_after", 32'(Dma_Ready), 32'h1);
      check("t1_tx_data_held", 32'(TX_Data), CS_EXTRA ? 32'h11 : 32'hBB);
      tick(5);
      check("t1_done_once", 32'(done_cnt), 32'd1);
      check("t1_cs_oen", 32'(cs_oen_bad), 32'd0);

      // 2: address wrap FE,FF,00,01
      clr();
      do_start(8'hFE, 5'd4);
      wait_done("t2", 1500);
      tick(5);
      check("t2_addr_n", 32'(addr_q.size()), 32'd4);
      check("t2_addr0", 32'(addr_q[0]), 32'hFE);
      check("t2_addr1", 32'(addr_q[1]), 32'hFF);
      check("t2_addr2", 32'(addr_q[2]), 32'h00);
      check("t2_addr3", 32'(addr_q[3]), 32'h01);
      check("t2_frames_n", 32'(frame_q.size()), 32'(4 + CS_EXTRA));
      check("t2_frame3", 32'(frame_q[3]), 32'h04);
      check("t2_done_once", 32'(done_cnt), 32'd1);

      // 3: zero length
      clr();
      do_start(8'h10, 5'd0);
      check("t3_done_pulse", 32'(Done), 32'h1);
      check("t3_ready", 32'(Dma_Ready), 32'h1);
      tick(1);
      check("t3_done_low", 32'(Done), 32'h0);
      tick(10);
      check("t3_done_once", 32'(done_cnt), 32'd1);
      check("t3_no_req", 32'(breq_cnt), 32'd0);
      check("t3_no_cs", 32'(cs_cnt), 32'd0);
      check("t3_no_txv", 32'(txv_cnt), 32'd0);

      // 4: grant withheld 50 request cycles
      clr();
      grant_delay = 50;
      do_start(8'h20, 5'd1);
      tick(30);
      check("t4_req_held", 32'(Bus_req), 32'h1);
      check("t4_cs_idle", 32'(Cs), 32'h0);
      wait_done("t4", 1500);
      check("t4_wait_len", 32'(first_grant - first_req), 32'd50);
      check("t4_read_lat", 32'(first_cs - first_grant), 32'd1);
      check("t4_no_early_cs", 32'(cs_early), 32'd0);
      check("t4_frame", 32'(frame_q[0]), 32'h5C);
      grant_delay = 1;
      tick(5);

      // 5: abort during byte 2 of 5, then a fresh run
      clr();
      do_start(8'h30, 5'd5);
      for (int n = 0; n < 500 && frame_q.size() < 2; n++) tick(1);
      check("t5_reached_byte2", 32'(frame_q.size()), 32'd2);
      Ena = 1'b0;
      tick(1);
      check("t5_idle", 32'(Dma_Ready), 32'h1);
      check("t5_req_low", 32'(Bus_req), 32'h0);
      clr();
      tick(10);
      Ena = 1'b1;
      tick(20);
      check("t5_no_req", 32'(breq_cnt), 32'd0);
      check("t5_no_done", 32'(done_cnt), 32'd0);
      check("t5_no_frames", 32'(frame_q.size()), 32'd0);
      check("t5_uart_finished", 32'(TX_Ready), 32'h1);
      do_start(8'h30, 5'd5);
      wait_done("t5_rerun", 1500);
      tick(5);
      check("t5_frames_n", 32'(frame_q.size()), 32'(5 + CS_EXTRA));
      check("t5_frame0", 32'(frame_q[0]), 32'h11);
      check("t5_frame4", 32'(frame_q[4]), 32'h55);
      check("t5_done_once", 32'(done_cnt), 32'd1);

      // 7: length above MAX_LEN saturates to 16
      clr();
      do_start(8'h50, 5'd20);
      wait_done("t7", 3000);
      tick(5);
      check("t7_addr_n", 32'(addr_q.size()), 32'd16);
      check("t7_addr_last", 32'(addr_q[15]), 32'h5F);
      check("t7_frames_n", 32'(frame_q.size()), 32'(16 + CS_EXTRA));

`ifdef DMA_TX_CHECKSUM_EN
      // 6: checksum byte after 0x12,0x34,0x56
      clr();
      do_start(8'h40, 5'd3);
      wait_done("t6", 1500);
      tick(5);
      check("t6_frames_n", 32'(frame_q.size()), 32'd4);
      check("t6_csum", 32'(frame_q[3]), 32'h70);
      check("t6_done_after_csum", 32'(frames_at_done), 32'd4);
      check("t6_done_once", 32'(done_cnt), 32'd1);
      check("t6_no_csum_bus", 32'(addr_q.size()), 32'd3);
`endif

      // Reset mid-transfer returns outputs immediately
      clr();
      do_start(8'h10, 5'd2);
      tick(2);
      #2;
      Rst = 1'b1;
      #1;
      check("rst_mid_bus_req", 32'(Bus_req), 32'h0);
      check("rst_mid_ready", 32'(Dma_Ready), 32'h1);
      check("rst_mid_tx_data", 32'(TX_Data), 32'h0);
      tick(2);
      Rst = 1'b0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
